// File: rtl/sid_write_master.sv
// Buffers SID register writes in a small FIFO and replays each one on the chip bus
// as a SETUP / STROBE / HOLD cycle with programmable phase lengths.
module sid_write_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_voice,
    input  logic [2:0] in_addr,
    input  logic [7:0] in_data,
    output logic [7:0] sid_ui,
    output logic [7:0] sid_uio,
    output logic       busy,
    output logic       wr_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [3:0]    SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0]    STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0]    HOLD_LD   = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    logic [12:0]   mem [FIFO_DEPTH];
    logic [12:0]   head;
    logic [12:0]   cmd_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic          push, pop, empty, full;
    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic          strobe_q, strobe_d, wr_done_d, busy_d;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign in_ready = !full;
    // A full FIFO refuses even when the sequencer pops on the same edge.
    assign push     = in_valid && !full;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_voice, in_addr, in_data};
    end

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + CNT_ONE;
        else if (pop && !push) count_next = count - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt holds the remaining cycles of the current phase; zero marks its last cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                    cnt_next   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_next = STROBE;
                    cnt_next   = STROBE_LD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 4'd1;
                end else if (!empty) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                    cnt_next   = SETUP_LD;
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are precomputed from next-state values so they leave the block registered.
    always_comb begin
        strobe_d  = (state_next == STROBE);
        wr_done_d = (state_next == HOLD) && (cnt_next == '0);
        busy_d    = (count_next != '0) || (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
            wr_done  <= 1'b0;
            busy     <= 1'b0;
            cmd_q    <= '0;
        end else begin
            strobe_q <= strobe_d;
            wr_done  <= wr_done_d;
            busy     <= busy_d;
            if (pop) cmd_q <= head;
        end
    end

    assign sid_ui  = {strobe_q, 2'b00, cmd_q[12:8]};
    assign sid_uio = cmd_q[7:0];

endmodule

// File: tb/tb_sid_write_master.sv
// Scoreboard bench for sid_write_master: default instance plus a 3/1/2 phase-length instance.
module tb_sid_write_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready;
    logic [1:0] in_voice;
    logic [2:0] in_addr;
    logic [7:0] in_data;
    logic [7:0] sid_ui, sid_uio;
    logic       busy, wr_done;

    logic       in_valid2, in_ready2;
    logic [1:0] in_voice2;
    logic [2:0] in_addr2;
    logic [7:0] in_data2;
    logic [7:0] sid_ui2, sid_uio2;
    logic       busy2, wr_done2;

    sid_write_master dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_voice(in_voice), .in_addr(in_addr), .in_data(in_data),
        .sid_ui(sid_ui), .sid_uio(sid_uio), .busy(busy), .wr_done(wr_done)
    );

    sid_write_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_voice(in_voice2), .in_addr(in_addr2), .in_data(in_data2),
        .sid_ui(sid_ui2), .sid_uio(sid_uio2), .busy(busy2), .wr_done(wr_done2)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [12:0] sb [$];
    int          n_push, n_pop, n_rise, width, last_rise;
    logic        prev_stb;
    logic [12:0] bus_prev;
    bit          chk_period;
    bit          saw_full;
    logic [7:0]  tr_ui [16];
    logic [7:0]  tr_uio [16];
    logic        tr_wd [16];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Per-cycle monitor of the default instance, sampled at the falling edge.
    task automatic mon();
        logic [12:0] bus, exp;
        logic        stb;
        if (!rst_n) begin
            sb.delete();
            n_push = 0; n_pop = 0; prev_stb = 1'b0; width = 0; last_rise = -1; bus_prev = '0;
            return;
        end
        bus = {sid_ui[4:0], sid_uio};
        stb = sid_ui[7];
        // Consecutive test commands always differ, so a bus change marks a pop.
        if (bus != bus_prev) n_pop++;
        bus_prev = bus;
        chk("in_ready_vs_occupancy", 32'(in_ready), 32'((n_push - n_pop) != 4));
        chk("wr_done_after_strobe", 32'(wr_done), 32'(prev_stb && !stb));
        if (stb && !prev_stb) begin
            n_rise++;
            chk("ui_pad_zero", 32'(sid_ui[6:5]), 0);
            if (sb.size() == 0) begin
                chk("strobe_without_command", 1, 0);
            end else begin
                exp = sb.pop_front();
                chk("strobe_bus", 32'(bus), 32'(exp));
            end
            if (chk_period && last_rise >= 0) chk("strobe_period", cyc - last_rise, 4);
            last_rise = cyc;
            width = 1;
        end else if (stb) begin
            width++;
        end else if (prev_stb) begin
            chk("strobe_width", width, 2);
        end
        prev_stb = stb;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mon();
    endtask

    task automatic send(input logic [12:0] c);
        int t = 0;
        in_valid = 1'b1;
        {in_voice, in_addr, in_data} = c;
        while (!in_ready && t < 100) begin
            saw_full = 1'b1;
            tick();
            t++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
        end else begin
            sb.push_back(c);
            n_push++;
        end
        tick();
    endtask

    task automatic drain();
        int t = 0;
        while (busy && t < 200) begin
            tick();
            t++;
        end
        chk("drain_busy", 32'(busy), 0);
        chk("drain_scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [12:0] burst [11];
        logic [12:0] a2, b2;
        int          r0;

        rst_n = 1'b0;
        in_valid = 1'b0; in_voice = '0; in_addr = '0; in_data = '0;
        in_valid2 = 1'b0; in_voice2 = '0; in_addr2 = '0; in_data2 = '0;
        prev_stb = 1'b0; width = 0; last_rise = -1; n_push = 0; n_pop = 0; n_rise = 0;
        bus_prev = '0; chk_period = 1'b0; saw_full = 1'b0;

        repeat (3) tick();
        chk("rst_sid_ui", 32'(sid_ui), 0);
        chk("rst_sid_uio", 32'(sid_uio), 0);
        chk("rst_wr_done", 32'(wr_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // Single write, offered on the first edge after reset release.
        rst_n = 1'b1;
        send({2'd0, 3'd0, 8'hD6});
        in_valid = 1'b0;
        tick();
        chk("single_n1_ui", 32'(sid_ui), 32'h00);
        chk("single_n1_uio", 32'(sid_uio), 32'hD6);
        tick();
        chk("single_n2_ui", 32'(sid_ui), 32'h80);
        tick();
        chk("single_n3_ui", 32'(sid_ui), 32'h80);
        chk("single_n3_uio", 32'(sid_uio), 32'hD6);
        tick();
        chk("single_n4_ui", 32'(sid_ui), 32'h00);
        chk("single_n4_wr_done", 32'(wr_done), 1);
        chk("single_n4_busy", 32'(busy), 1);
        tick();
        chk("single_n5_wr_done", 32'(wr_done), 0);
        chk("single_n5_busy", 32'(busy), 0);
        chk("single_n5_uio_held", 32'(sid_uio), 32'hD6);

        // Push coinciding with the HOLD-exit pop while three entries are queued.
        send({2'd1, 3'd0, 8'h10});
        send({2'd1, 3'd1, 8'h20});
        send({2'd1, 3'd2, 8'h30});
        send({2'd1, 3'd3, 8'h40});
        in_valid = 1'b0;
        tick();
        send({2'd1, 3'd4, 8'h50});
        chk("pushpop_ready_at_3", 32'(in_ready), 1);
        send({2'd2, 3'd7, 8'h60});
        in_valid = 1'b0;
        chk("pushpop_full_after_one_push", 32'(in_ready), 0);
        drain();

        // SID setup burst: eleven writes back to back.
        burst[0]  = {2'd0, 3'd0, 8'hD6}; burst[1]  = {2'd0, 3'd1, 8'h1C};
        burst[2]  = {2'd0, 3'd2, 8'h00}; burst[3]  = {2'd0, 3'd3, 8'h08};
        burst[4]  = {2'd0, 3'd4, 8'h10}; burst[5]  = {2'd0, 3'd5, 8'h09};
        burst[6]  = {2'd3, 3'd0, 8'h00}; burst[7]  = {2'd3, 3'd1, 8'h00};
        burst[8]  = {2'd3, 3'd2, 8'h00}; burst[9]  = {2'd3, 3'd3, 8'h0F};
        burst[10] = {2'd0, 3'd6, 8'h11};
        chk_period = 1'b1;
        last_rise = -1;
        r0 = n_rise;
        for (int i = 0; i < 11; i++) send(burst[i]);
        in_valid = 1'b0;
        drain();
        chk("burst_strobe_count", n_rise - r0, 11);
        chk_period = 1'b0;

        // Six commands with in_valid held high against a four-entry FIFO.
        saw_full = 1'b0;
        r0 = n_rise;
        for (int i = 0; i < 6; i++) send({2'd1, 3'(i), 8'hA0 + 8'(i)});
        in_valid = 1'b0;
        chk("full_backpressure_seen", 32'(saw_full), 1);
        drain();
        chk("full_strobe_count", n_rise - r0, 6);

        // Reset asserted during STROBE with three commands still queued.
        for (int i = 0; i < 4; i++) send({2'd3, 3'(i), 8'hC0 + 8'(i)});
        in_valid = 1'b0;
        chk("pre_reset_strobe_high", 32'(sid_ui[7]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_sid_ui", 32'(sid_ui), 0);
        chk("reset_async_sid_uio", 32'(sid_uio), 0);
        chk("reset_async_busy", 32'(busy), 0);
        chk("reset_async_in_ready", 32'(in_ready), 1);
        tick();
        tick();
        rst_n = 1'b1;
        r0 = n_rise;
        repeat (20) tick();
        chk("post_reset_no_strobes", n_rise - r0, 0);
        chk("post_reset_busy", 32'(busy), 0);
        send({2'd1, 3'd2, 8'hAA});
        in_valid = 1'b0;
        drain();
        chk("post_reset_new_write", n_rise - r0, 1);

        // Phase-length sweep on the 3/1/2 instance.
        a2 = {2'd2, 3'd5, 8'h5A};
        b2 = {2'd3, 3'd6, 8'hA5};
        chk("p2_ready_idle", 32'(in_ready2), 1);
        in_valid2 = 1'b1;
        {in_voice2, in_addr2, in_data2} = a2;
        tick();
        tr_ui[0] = sid_ui2; tr_uio[0] = sid_uio2; tr_wd[0] = wr_done2;
        {in_voice2, in_addr2, in_data2} = b2;
        tick();
        tr_ui[1] = sid_ui2; tr_uio[1] = sid_uio2; tr_wd[1] = wr_done2;
        in_valid2 = 1'b0;
        for (int i = 2; i < 16; i++) begin
            tick();
            tr_ui[i] = sid_ui2; tr_uio[i] = sid_uio2; tr_wd[i] = wr_done2;
        end
        for (int i = 0; i < 16; i++) begin
            logic [12:0] eb;
            eb = (i == 0) ? 13'h0 : (i <= 6) ? a2 : b2;
            chk($sformatf("p2_strobe[%0d]", i), 32'(tr_ui[i][7]), 32'(i == 4 || i == 10));
            chk($sformatf("p2_bus[%0d]", i), 32'({tr_ui[i][4:0], tr_uio[i]}), 32'(eb));
            chk($sformatf("p2_wr_done[%0d]", i), 32'(tr_wd[i]), 32'(i == 6 || i == 12));
        end
        chk("p2_busy_end", 32'(busy2), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
